// File: rtl/pipe_stage_reg_pkg.sv
// Shared types and constants for the MIPS pipeline-stage register (package pipe_pkg).
// Holds the occupancy state enum, control-bit positions and default widths.
package pipe_pkg;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_NUM_LANES = 4;
  localparam int DEF_CTRL_W    = 8;

  // Bit positions inside the control vector carried alongside the data lanes.
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_JAL      = 2;
  localparam int CTRL_MEMREAD  = 3;
  localparam int CTRL_MEMWRITE = 4;
  localparam int CTRL_BRANCH   = 5;
  localparam int CTRL_ALUSRC   = 6;
  localparam int CTRL_REGDST   = 7;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_e;

  function automatic logic [1:0] occ_of(input pipe_state_e s);
    case (s)
      ST_ONE:  occ_of = 2'd1;
      ST_TWO:  occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Bundle of flush, upstream/downstream handshake, payload and status signals
// for one pipeline-stage register. slave = the stage, master = its environment.
interface pipe_stage_reg_if #(
  parameter int DATA_W    = pipe_pkg::DEF_DATA_W,
  parameter int NUM_LANES = pipe_pkg::DEF_NUM_LANES,
  parameter int CTRL_W    = pipe_pkg::DEF_CTRL_W
);
  import pipe_pkg::*;

  // Handshake: a transfer happens on a rising clock edge where valid and ready
  // are both 1 (In_Valid/In_Ready upstream, Out_Valid/Out_Ready downstream).
  // A valid source holds data/ctrl stable until the transfer; Flush overrides
  // everything and empties the stage at the next edge.
  logic                        Flush;
  logic                        In_Valid;
  logic                        In_Ready;
  logic [NUM_LANES*DATA_W-1:0] In_Data;
  logic [CTRL_W-1:0]           In_Ctrl;
  logic                        Out_Valid;
  logic                        Out_Ready;
  logic [NUM_LANES*DATA_W-1:0] Out_Data;
  logic [CTRL_W-1:0]           Out_Ctrl;
  logic [1:0]                  Occupancy;
  pipe_state_e                 Dbg_State;

  modport slave (
    input  Flush, In_Valid, In_Data, In_Ctrl, Out_Ready,
    output In_Ready, Out_Valid, Out_Data, Out_Ctrl, Occupancy, Dbg_State
  );

  modport master (
    output Flush, In_Valid, In_Data, In_Ctrl, Out_Ready,
    input  In_Ready, Out_Valid, Out_Data, Out_Ctrl, Occupancy, Dbg_State
  );

endinterface

// File: rtl/pipe_stage_reg_slot.sv
// One enable-loadable {ctrl, data} register with asynchronous active-low reset.
// Used for the main output register and, when present, the skid register.
module pipe_stage_slot #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline-stage register with valid/ready flow control and flush.
// Define PIPE_STAGE_SKID_EN for a two-entry skid buffer with registered In_Ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                 DATA_W      = DEF_DATA_W,
  parameter int                 NUM_LANES   = DEF_NUM_LANES,
  parameter int                 CTRL_W      = DEF_CTRL_W,
  parameter logic [CTRL_W-1:0]  BUBBLE_CTRL = '0
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  pipe_stage_reg_if.slave       bus
);

  localparam int DW     = NUM_LANES * DATA_W;
  localparam int SLOT_W = CTRL_W + DW;

  pipe_state_e       state_q, state_d;
  logic              out_valid;
  logic              in_ready;
  logic              accept;
  logic              emit;
  logic              main_en;
  logic [SLOT_W-1:0] in_word;
  logic [SLOT_W-1:0] main_d;
  logic [SLOT_W-1:0] main_q;

  assign in_word   = {bus.In_Ctrl, bus.In_Data};
  assign out_valid = (state_q != ST_EMPTY);

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_en;
  logic              main_from_skid;
  logic [SLOT_W-1:0] skid_q;

  // Ready is a decode of registered state only, so no path from Out_Ready.
  assign in_ready = RST_N & (state_q != ST_TWO);
  assign main_d   = main_from_skid ? skid_q : in_word;

  pipe_stage_slot #(.W(SLOT_W)) u_skid (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .en_i   (skid_en),
    .d_i    (in_word),
    .q_o    (skid_q)
  );
`else
  assign in_ready = RST_N & (bus.Out_Ready | ~out_valid);
  assign main_d   = in_word;
`endif

  assign accept = bus.In_Valid & in_ready;
  assign emit   = out_valid & bus.Out_Ready;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_en = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    skid_en        = 1'b0;
    main_from_skid = 1'b0;
`endif
    // Flush wins: an accept in the same cycle is consumed and dropped.
    if (bus.Flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_ONE;
            main_en = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && emit) begin
            main_en = 1'b1;
          end else if (accept) begin
`ifdef PIPE_STAGE_SKID_EN
            state_d = ST_TWO;
            skid_en = 1'b1;
`endif
          end else if (emit) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
`ifdef PIPE_STAGE_SKID_EN
          if (emit) begin
            state_d        = ST_ONE;
            main_en        = 1'b1;
            main_from_skid = 1'b1;
          end
`else
          state_d = ST_EMPTY;
`endif
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  pipe_stage_slot #(.W(SLOT_W)) u_main (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .en_i   (main_en),
    .d_i    (main_d),
    .q_o    (main_q)
  );

  assign bus.In_Ready  = in_ready;
  assign bus.Out_Valid = out_valid;
  assign bus.Out_Data  = main_q[DW-1:0];
  assign bus.Out_Ctrl  = out_valid ? main_q[SLOT_W-1:DW] : BUBBLE_CTRL;
  assign bus.Occupancy = occ_of(state_q);
  assign bus.Dbg_State = state_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg; covers both the skid and
// the pass-through build depending on PIPE_STAGE_SKID_EN.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int DATA_W    = 32;
  localparam int NUM_LANES = 4;
  localparam int CTRL_W    = 8;
  localparam int DW        = DATA_W * NUM_LANES;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DATA_W(DATA_W), .NUM_LANES(NUM_LANES), .CTRL_W(CTRL_W)) bus ();

  pipe_stage_reg #(
    .DATA_W      (DATA_W),
    .NUM_LANES   (NUM_LANES),
    .CTRL_W      (CTRL_W),
    .BUBBLE_CTRL (8'h00)
  ) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_data(input logic [31:0] v);
    return {v ^ 32'h0300, v ^ 32'h0200, v ^ 32'h0100, v};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [7:0] c);
    bus.In_Valid = v;
    bus.In_Data  = mk_data(d);
    bus.In_Ctrl  = c;
  endtask

  initial begin
    logic [DW-1:0] exp_d;
    bus.Flush     = 1'b0;
    bus.Out_Ready = 1'b1;
    drive(1'b0, 32'h0, 8'h00);

    // Reset state, sampled while RST_N is still low.
    #12;
    check_eq("rst_in_ready", bus.In_Ready, 1'b0);
    check_eq("rst_out_valid", bus.Out_Valid, 1'b0);
    check_eq("rst_out_ctrl", bus.Out_Ctrl, 8'h00);
    check_eq("rst_occ", bus.Occupancy, 2'd0);
    check_eq("rst_out_data", bus.Out_Data, '0);
    #1 rst_n = 1'b1;
    #1 check_eq("rst_release_in_ready", bus.In_Ready, 1'b1);
    step();

    // Single entry: 1-cycle latency then drain.
    drive(1'b1, 32'h0000_1234, 8'((1 << CTRL_REGWRITE) | (1 << CTRL_JAL)));
    step();
    check_eq("single_valid", bus.Out_Valid, 1'b1);
    check_eq("single_lane0", bus.Out_Data[31:0], 32'h0000_1234);
    check_eq("single_ctrl", bus.Out_Ctrl, 8'h05);
    check_eq("single_occ", bus.Occupancy, 2'd1);
    drive(1'b0, 32'h0, 8'h00);
    step();
    check_eq("single_drain_valid", bus.Out_Valid, 1'b0);
    check_eq("single_drain_bubble", bus.Out_Ctrl, 8'h00);
    check_eq("single_drain_occ", bus.Occupancy, 2'd0);

    // Back-to-back stream 1..8 with Out_Ready held high.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 32'(i), 8'(i));
      check_eq("stream_in_ready", bus.In_Ready, 1'b1);
      exp_q.push_back(mk_data(32'(i)));
      step();
      exp_d = exp_q.pop_front();
      check_eq("stream_valid", bus.Out_Valid, 1'b1);
      check_eq("stream_data", bus.Out_Data, exp_d);
      check_eq("stream_ctrl", bus.Out_Ctrl, 8'(i));
    end
    drive(1'b0, 32'h0, 8'h00);
    step();
    check_eq("stream_end_valid", bus.Out_Valid, 1'b0);

`ifdef PIPE_STAGE_SKID_EN
    // Stall fills the skid; order and ready timing on release.
    bus.Out_Ready = 1'b0;
    drive(1'b1, 32'hA, 8'h03);
    step();
    check_eq("stall_a_occ", bus.Occupancy, 2'd1);
    check_eq("stall_a_in_ready", bus.In_Ready, 1'b1);
    drive(1'b1, 32'hB, 8'h04);
    step();
    check_eq("stall_two_occ", bus.Occupancy, 2'd2);
    check_eq("stall_two_in_ready", bus.In_Ready, 1'b0);
    check_eq("stall_two_state", bus.Dbg_State, ST_TWO);
    check_eq("stall_two_lane0", bus.Out_Data[31:0], 32'hA);
    check_eq("stall_two_ctrl", bus.Out_Ctrl, 8'h03);
    drive(1'b1, 32'hD, 8'h09);
    step();
    check_eq("stall_hold_occ", bus.Occupancy, 2'd2);
    check_eq("stall_hold_data", bus.Out_Data, mk_data(32'hA));
    drive(1'b0, 32'h0, 8'h00);
    bus.Out_Ready = 1'b1;
    #1 check_eq("stall_ready_registered", bus.In_Ready, 1'b0);
    step();
    check_eq("release_b_data", bus.Out_Data, mk_data(32'hB));
    check_eq("release_b_ctrl", bus.Out_Ctrl, 8'h04);
    check_eq("release_in_ready", bus.In_Ready, 1'b1);
    check_eq("release_occ", bus.Occupancy, 2'd1);
    step();
    check_eq("release_empty", bus.Out_Valid, 1'b0);

    // Flush with two held entries and a new entry offered.
    bus.Out_Ready = 1'b0;
    drive(1'b1, 32'h1A, 8'h01);
    step();
    drive(1'b1, 32'h1B, 8'h02);
    step();
    check_eq("flush2_pre_occ", bus.Occupancy, 2'd2);
    bus.Flush = 1'b1;
    drive(1'b1, 32'hC, 8'h07);
    step();
    check_eq("flush2_valid", bus.Out_Valid, 1'b0);
    check_eq("flush2_bubble", bus.Out_Ctrl, 8'h00);
    check_eq("flush2_occ", bus.Occupancy, 2'd0);
    check_eq("flush2_in_ready", bus.In_Ready, 1'b1);
    bus.Flush = 1'b0;
    drive(1'b0, 32'h0, 8'h00);
    bus.Out_Ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("flush2_no_c", bus.Out_Valid, 1'b0);
    end
`else
    // Pass-through: ready follows Out_Ready combinationally, never two held.
    bus.Out_Ready = 1'b0;
    drive(1'b1, 32'h55, 8'h11);
    step();
    check_eq("nsk_valid", bus.Out_Valid, 1'b1);
    check_eq("nsk_in_ready_low", bus.In_Ready, 1'b0);
    drive(1'b1, 32'h66, 8'h22);
    step();
    check_eq("nsk_occ_max", bus.Occupancy, 2'd1);
    check_eq("nsk_hold_data", bus.Out_Data, mk_data(32'h55));
    check_eq("nsk_hold_ctrl", bus.Out_Ctrl, 8'h11);
    bus.Out_Ready = 1'b1;
    #1 check_eq("nsk_in_ready_comb", bus.In_Ready, 1'b1);
    step();
    check_eq("nsk_next_data", bus.Out_Data, mk_data(32'h66));
    check_eq("nsk_next_occ", bus.Occupancy, 2'd1);
    drive(1'b0, 32'h0, 8'h00);
    step();
    check_eq("nsk_drain", bus.Out_Valid, 1'b0);
`endif

    // Flush in ONE with a simultaneous accept: the new entry is dropped.
    bus.Out_Ready = 1'b1;
    drive(1'b1, 32'h77, 8'h01);
    step();
    check_eq("flush1_pre_occ", bus.Occupancy, 2'd1);
    bus.Flush = 1'b1;
    drive(1'b1, 32'hE, 8'h0E);
    step();
    check_eq("flush1_valid", bus.Out_Valid, 1'b0);
    check_eq("flush1_bubble", bus.Out_Ctrl, 8'h00);
    check_eq("flush1_occ", bus.Occupancy, 2'd0);
    bus.Flush = 1'b0;
    drive(1'b0, 32'h0, 8'h00);
    step();
    check_eq("flush1_no_e", bus.Out_Valid, 1'b0);

    // Asynchronous reset mid-stream, between clock edges.
    bus.Out_Ready = 1'b0;
    drive(1'b1, 32'h99, 8'h05);
    step();
    check_eq("arst_pre_occ", bus.Occupancy, 2'd1);
    drive(1'b0, 32'h0, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_valid", bus.Out_Valid, 1'b0);
    check_eq("arst_data", bus.Out_Data, '0);
    check_eq("arst_occ", bus.Occupancy, 2'd0);
    check_eq("arst_ctrl", bus.Out_Ctrl, 8'h00);
    check_eq("arst_in_ready", bus.In_Ready, 1'b0);
    #1 rst_n = 1'b1;
    #1 check_eq("arst_release_in_ready", bus.In_Ready, 1'b1);
    step();
    check_eq("arst_after_valid", bus.Out_Valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
